rw_regfile_sb: RTL and testbench

- Parametrised register-file and write-back unit for the Simple_RISC pipeline; next generation of the RW stage.
- Adds configurable width, depth and read-port count; a decoupled load-return channel with a 1-entry hold buffer; a per-register busy scoreboard; optional write-to-read bypass.
- Sits between MA/RW (writers) and OF (readers and issue logic).

---
 rtl/rw_pkg.sv | 20 ++
 rtl/rw_hold_buf.sv | 43 ++++
 rtl/rw_regfile_sb.sv | 132 +++++++++++++
 tb/tb_rw_regfile_sb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_pkg.sv
// Shared defaults and write-port selector type for the rw_regfile_sb register file.
package rw_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int NREGS_DEF  = 16;
   localparam int PC_INC_DEF = 4;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_PRI,
      WB_HOLD,
      WB_LD
   } wb_sel_e;

   // Call write-back targets the top register unless overridden.
   function automatic int link_reg_def(input int nregs);
      return nregs - 1;
   endfunction

endpackage

// File: rtl/rw_hold_buf.sv
// One-entry holding register for a load beat that lost the write port to a primary write.
module rw_hold_buf #(
   parameter int XLEN = 32,
   parameter int AW   = 4
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            capture_i,
   input  logic            drain_i,
   input  logic [AW-1:0]   rd_i,
   input  logic [XLEN-1:0] data_i,
   output logic            full_o,
   output logic [AW-1:0]   rd_o,
   output logic [XLEN-1:0] data_o
);

   logic            full_q;
   logic [AW-1:0]   rd_q;
   logic [XLEN-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full_q <= 1'b0;
      end else if (capture_i) begin
         full_q <= 1'b1;
      end else if (drain_i) begin
         full_q <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed while full_q is set.
   always_ff @(posedge clk_i) begin
      if (capture_i) begin
         rd_q   <= rd_i;
         data_q <= data_i;
      end
   end

   assign full_o = full_q;
   assign rd_o   = rd_q;
   assign data_o = data_q;

endmodule

// File: rtl/rw_regfile_sb.sv
// Register file with write-back arbitration, load hold buffer, busy scoreboard and read bypass.
module rw_regfile_sb
   import rw_pkg::*;
#(
   parameter int  XLEN     = XLEN_DEF,
   parameter int  NREGS    = NREGS_DEF,
   parameter int  NRP      = 2,
   parameter int  LINK_REG = link_reg_def(NREGS),
   parameter int  PC_INC   = PC_INC_DEF,
   parameter bit  BYPASS   = 1'b1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              isWb,
   input  logic              isCall,
   input  logic [AW-1:0]     Rd,
   input  logic [XLEN-1:0]   aluResult,
   input  logic [XLEN-1:0]   pc_current,
   input  logic              ld_valid,
   input  logic [AW-1:0]     ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   output logic              ld_ready,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NRP*AW-1:0] rd_addr,
   output logic [NRP*XLEN-1:0] rd_data,
   output logic [NRP-1:0]    rd_busy
);

   localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;

   logic            hold_full, hold_capture, hold_drain;
   logic [AW-1:0]   hold_rd;
   logic [XLEN-1:0] hold_data;

   logic            ld_live;
   wb_sel_e         wb_sel;
   logic [AW-1:0]   pri_addr, wr_addr;
   logic [XLEN-1:0] pri_data, wr_data;
   logic            wr_en;

   rw_hold_buf #(.XLEN(XLEN), .AW(AW)) u_hold (
      .clk_i    (Clk),
      .reset_i  (reset),
      .capture_i(hold_capture),
      .drain_i  (hold_drain),
      .rd_i     (ld_rd),
      .data_i   (ld_data),
      .full_o   (hold_full),
      .rd_o     (hold_rd),
      .data_o   (hold_data)
   );

   assign ld_ready = !hold_full;
   // Loads to R0 are accepted but never take the write port or the buffer.
   assign ld_live  = ld_valid && !hold_full && (ld_rd != '0);

   assign pri_addr = isCall ? LINK_A : Rd;
   assign pri_data = isCall ? (pc_current + XLEN'(PC_INC)) : aluResult;

   always_comb begin
      wb_sel       = WB_NONE;
      hold_capture = 1'b0;
      hold_drain   = 1'b0;
      wr_addr      = pri_addr;
      wr_data      = pri_data;
      if (isWb) begin
         wb_sel       = WB_PRI;
         hold_capture = ld_live;
      end else if (hold_full) begin
         wb_sel     = WB_HOLD;
         hold_drain = 1'b1;
         wr_addr    = hold_rd;
         wr_data    = hold_data;
      end else if (ld_live) begin
         wb_sel  = WB_LD;
         wr_addr = ld_rd;
         wr_data = ld_data;
      end
   end

   assign wr_en = (wb_sel != WB_NONE) && (wr_addr != '0);

   always_ff @(posedge Clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Issue is applied after the write clear so a same-register issue keeps busy set.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (iss_valid) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            rbsy;

      assign ra = rd_addr[k*AW +: AW];

      always_comb begin
         rdat = regs_q[ra];
         rbsy = busy_q[ra];
         if (ra == '0) begin
            rdat = '0;
            rbsy = 1'b0;
         end else if (BYPASS && wr_en && (ra == wr_addr)) begin
            rdat = wr_data;
            rbsy = iss_valid && (iss_rd == ra);
         end
      end

      assign rd_data[k*XLEN +: XLEN] = rdat;
      assign rd_busy[k]              = rbsy;
   end

endmodule

// File: tb/tb_rw_regfile_sb.sv
// Scoreboard bench: bypass and non-bypass 16x32 instances share stimulus; a 32x64 3-port instance runs separately.
module tb_rw_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, isWb, isCall, ld_valid, iss_valid;
   logic [3:0]  Rd, ld_rd, iss_rd;
   logic [31:0] aluResult, pc_current, ld_data;
   logic [7:0]  rd_addr;
   logic        ld_ready0, ld_ready1;
   logic [63:0] rd_data0, rd_data1;
   logic [1:0]  rd_busy0, rd_busy1;

   logic         b_reset, b_isWb, b_isCall, b_ld_valid, b_iss_valid, b_ld_ready;
   logic [4:0]   b_Rd, b_ld_rd, b_iss_rd;
   logic [63:0]  b_alu, b_pc, b_ld_data;
   logic [14:0]  b_rd_addr;
   logic [191:0] b_rd_data;
   logic [2:0]   b_rd_busy;

   rw_regfile_sb #(.BYPASS(1'b1)) d0 (
      .Clk(clk), .reset(reset), .isWb(isWb), .isCall(isCall), .Rd(Rd),
      .aluResult(aluResult), .pc_current(pc_current), .ld_valid(ld_valid),
      .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready0), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0));

   rw_regfile_sb #(.BYPASS(1'b0)) d1 (
      .Clk(clk), .reset(reset), .isWb(isWb), .isCall(isCall), .Rd(Rd),
      .aluResult(aluResult), .pc_current(pc_current), .ld_valid(ld_valid),
      .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready1), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1));

   rw_regfile_sb #(.XLEN(64), .NREGS(32), .NRP(3)) d2 (
      .Clk(clk), .reset(b_reset), .isWb(b_isWb), .isCall(b_isCall), .Rd(b_Rd),
      .aluResult(b_alu), .pc_current(b_pc), .ld_valid(b_ld_valid),
      .ld_rd(b_ld_rd), .ld_data(b_ld_data), .ld_ready(b_ld_ready), .iss_valid(b_iss_valid),
      .iss_rd(b_iss_rd), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy));

   typedef struct {
      string       name;
      int          dut;
      int          port;   // -1 selects ld_ready, compared against busy field
      logic [63:0] data;
      logic        busy;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic push(input string n, input int dut, input int port,
                       input logic [63:0] d, input logic b);
      exp_t e;
      e.name = n; e.dut = dut; e.port = port; e.data = d; e.busy = b;
      sb_q.push_back(e);
   endtask

   task automatic both(input string n, input int port, input logic [63:0] d, input logic b);
      push(n, 0, port, d, b);
      push(n, 1, port, d, b);
   endtask

   task automatic rdy(input string n, input logic r);
      push(n, 0, -1, 64'd0, r);
      push(n, 1, -1, 64'd0, r);
   endtask

   task automatic setrd(input logic [3:0] a0, input logic [3:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; isWb = 1'b0; isCall = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
      Rd = 4'd0; ld_rd = 4'd0; iss_rd = 4'd0;
      aluResult = 32'd0; pc_current = 32'd0; ld_data = 32'd0;
   endtask

   // Monitor: compares every queued expectation against the outputs presented this cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] ad;
      logic        ab;
      while (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         ad = 64'd0;
         ab = 1'b0;
         if (e.port < 0) begin
            case (e.dut)
               0:       ab = ld_ready0;
               1:       ab = ld_ready1;
               default: ab = b_ld_ready;
            endcase
         end else begin
            case (e.dut)
               0: begin ad = {32'd0, rd_data0[e.port*32 +: 32]}; ab = rd_busy0[e.port]; end
               1: begin ad = {32'd0, rd_data1[e.port*32 +: 32]}; ab = rd_busy1[e.port]; end
               default: begin ad = b_rd_data[e.port*64 +: 64]; ab = b_rd_busy[e.port]; end
            endcase
         end
         n_checks++;
         if (ad !== e.data || ab !== e.busy) begin
            n_errors++;
            $display("FAIL %s dut%0d port%0d: got data=%h busy/ready=%b, want data=%h busy/ready=%b",
                     e.name, e.dut, e.port, ad, ab, e.data, e.busy);
         end
      end
   end

   initial begin
      idle();
      reset = 1'b1;
      rd_addr = 8'd0;
      b_reset = 1'b1; b_isWb = 1'b0; b_isCall = 1'b0; b_ld_valid = 1'b0; b_iss_valid = 1'b0;
      b_Rd = 5'd0; b_ld_rd = 5'd0; b_iss_rd = 5'd0;
      b_alu = 64'd0; b_pc = 64'd0; b_ld_data = 64'd0; b_rd_addr = 15'd0;
      step();
      reset = 1'b0; b_reset = 1'b0;

      // Post-reset: every register zero and idle, load channel open
      for (int r = 0; r < 16; r++) begin
         setrd(4'(r), 4'(15 - r));
         both("rst_p0", 0, 64'd0, 1'b0);
         both("rst_p1", 1, 64'd0, 1'b0);
         rdy("rst_ready", 1'b1);
         step();
      end

      // Write then reset with a competing write
      setrd(4'd1, 4'd1);
      isWb = 1'b1; Rd = 4'd3; aluResult = 32'hDEADBEEF;
      step();
      idle(); setrd(4'd3, 4'd0);
      both("r3_write", 0, 64'hDEADBEEF, 1'b0);
      step();
      reset = 1'b1; isWb = 1'b1; Rd = 4'd3; aluResult = 32'h12345678;
      step();
      idle(); setrd(4'd3, 4'd0);
      both("r3_after_reset", 0, 64'd0, 1'b0);
      step();

      // Call writes link register, Rd ignored
      isWb = 1'b1; isCall = 1'b1; Rd = 4'd5; pc_current = 32'h100;
      step();
      idle(); setrd(4'd15, 4'd5);
      both("call_link", 0, 64'h104, 1'b0);
      both("call_rd_untouched", 1, 64'd0, 1'b0);
      step();

      // R0 hardwired zero
      isWb = 1'b1; Rd = 4'd0; aluResult = 32'h55;
      step();
      idle(); setrd(4'd0, 4'd0);
      both("r0_zero", 0, 64'd0, 1'b0);
      step();

      // Primary write collides with a load: load parked, then drained
      isWb = 1'b1; Rd = 4'd2; aluResult = 32'h11;
      ld_valid = 1'b1; ld_rd = 4'd4; ld_data = 32'h22;
      setrd(4'd1, 4'd1);
      rdy("collide_ready", 1'b1);
      step();
      isWb = 1'b0; ld_rd = 4'd8; ld_data = 32'h88;
      setrd(4'd2, 4'd4);
      rdy("hold_full_ready", 1'b0);
      both("r2_pri", 0, 64'h11, 1'b0);
      push("drain_bypass", 0, 1, 64'h22, 1'b0);
      push("drain_nobypass", 1, 1, 64'd0, 1'b0);
      step();
      setrd(4'd4, 4'd8);
      rdy("ready_after_drain", 1'b1);
      both("r4_drained", 0, 64'h22, 1'b0);
      push("held_ld_bypass", 0, 1, 64'h88, 1'b0);
      push("held_ld_nobypass", 1, 1, 64'd0, 1'b0);
      step();
      idle(); setrd(4'd8, 4'd2);
      both("r8_held_load", 0, 64'h88, 1'b0);
      both("r2_still", 1, 64'h11, 1'b0);
      step();

      // Scoreboard set by issue, cleared by load write
      iss_valid = 1'b1; iss_rd = 4'd6; setrd(4'd1, 4'd1);
      step();
      idle(); setrd(4'd6, 4'd0);
      both("busy6_set", 0, 64'd0, 1'b1);
      step();
      ld_valid = 1'b1; ld_rd = 4'd6; ld_data = 32'h77; setrd(4'd6, 4'd6);
      push("ld6_bypass", 0, 0, 64'h77, 1'b0);
      push("ld6_nobypass", 1, 0, 64'd0, 1'b1);
      step();
      idle(); setrd(4'd6, 4'd0);
      both("r6_stored", 0, 64'h77, 1'b0);
      step();

      // Issue and write to the same register: set wins
      iss_valid = 1'b1; iss_rd = 4'd7; isWb = 1'b1; Rd = 4'd7; aluResult = 32'h99;
      setrd(4'd7, 4'd0);
      push("r7_iss_wb_bypass", 0, 0, 64'h99, 1'b1);
      push("r7_iss_wb_nobypass", 1, 0, 64'd0, 1'b0);
      step();
      idle(); setrd(4'd7, 4'd0);
      both("r7_busy_kept", 0, 64'h99, 1'b1);
      step();
      isWb = 1'b1; Rd = 4'd7; aluResult = 32'hAA;
      push("r7_clear_bypass", 0, 0, 64'hAA, 1'b0);
      push("r7_clear_nobypass", 1, 0, 64'h99, 1'b1);
      step();
      idle(); setrd(4'd7, 4'd0);
      both("r7_cleared", 0, 64'hAA, 1'b0);
      step();

      // Load to R0 with primary write: discarded, buffer stays empty
      isWb = 1'b1; Rd = 4'd9; aluResult = 32'h5;
      ld_valid = 1'b1; ld_rd = 4'd0; ld_data = 32'hFF;
      step();
      idle(); setrd(4'd0, 4'd9);
      rdy("ld_r0_no_hold", 1'b1);
      both("ld_r0_zero", 0, 64'd0, 1'b0);
      both("r9_pri", 1, 64'h5, 1'b0);
      step();

      // Primary write while the buffer is full keeps it full
      isWb = 1'b1; Rd = 4'd10; aluResult = 32'hA0;
      ld_valid = 1'b1; ld_rd = 4'd11; ld_data = 32'hB0;
      step();
      ld_valid = 1'b0; Rd = 4'd12; aluResult = 32'hC0; setrd(4'd10, 4'd0);
      rdy("full_pri_ready", 1'b0);
      both("r10", 0, 64'hA0, 1'b0);
      step();
      idle(); setrd(4'd12, 4'd11);
      rdy("still_full_ready", 1'b0);
      both("r12", 0, 64'hC0, 1'b0);
      push("r11_drain_bypass", 0, 1, 64'hB0, 1'b0);
      push("r11_drain_nobypass", 1, 1, 64'd0, 1'b0);
      step();
      setrd(4'd11, 4'd10);
      rdy("emptied_ready", 1'b1);
      both("r11", 0, 64'hB0, 1'b0);
      both("r10_again", 1, 64'hA0, 1'b0);
      step();

      // Reset drops a held load and clears busy
      isWb = 1'b1; Rd = 4'd13; aluResult = 32'hD0;
      ld_valid = 1'b1; ld_rd = 4'd14; ld_data = 32'hE0;
      iss_valid = 1'b1; iss_rd = 4'd5;
      step();
      idle(); reset = 1'b1;
      rdy("pre_reset_full", 1'b0);
      step();
      reset = 1'b0; setrd(4'd14, 4'd5);
      rdy("reset_drop_ready", 1'b1);
      both("r14_dropped", 0, 64'd0, 1'b0);
      both("busy5_reset", 1, 64'd0, 1'b0);
      step();
      setrd(4'd13, 4'd11);
      both("r13_reset", 0, 64'd0, 1'b0);
      both("r11_reset", 1, 64'd0, 1'b0);
      step();

      // Wide instance: 64-bit, 32 regs, 3 read ports
      b_isWb = 1'b1; b_isCall = 1'b1; b_Rd = 5'd5; b_pc = 64'h1_0000_0000;
      step();
      b_isCall = 1'b0; b_Rd = 5'd1; b_alu = 64'h1111_2222_3333_4444;
      step();
      b_Rd = 5'd2; b_alu = 64'hAAAA_BBBB_CCCC_DDDD;
      b_rd_addr = {5'd2, 5'd1, 5'd31};
      push("w_link", 2, 0, 64'h1_0000_0004, 1'b0);
      push("w_r1", 2, 1, 64'h1111_2222_3333_4444, 1'b0);
      push("w_r2_bypass", 2, 2, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      step();
      b_isCall = 1'b1; b_Rd = 5'd5; b_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      b_rd_addr = {5'd31, 5'd2, 5'd1};
      push("w_r1_p0", 2, 0, 64'h1111_2222_3333_4444, 1'b0);
      push("w_r2_p1", 2, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      push("w_link_wrap_bypass", 2, 2, 64'd2, 1'b0);
      step();
      b_isWb = 1'b0; b_isCall = 1'b0;
      b_rd_addr = {5'd0, 5'd5, 5'd31};
      push("w_link_wrap", 2, 0, 64'd2, 1'b0);
      push("w_r5_untouched", 2, 1, 64'd0, 1'b0);
      push("w_r0", 2, 2, 64'd0, 1'b0);
      step();

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_queue: %0d expectations left unchecked, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
